// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Taken branches redirect the PC and squash IF/ID for FLUSH_BUBBLES cycles.
// Load-use stalls freeze the stage while it is running normally.
//
// Ports
//   clk_i            in   clock, rising edge
//   rst_i            in   synchronous reset, active low
//   pc_plus4_i       in   external adder result (pc_o + 4)
//   instr_i          in   instruction memory read data at pc_o
//   stall_i          in   hold request (load-use hazard)
//   branch_taken_i   in   redirect request
//   branch_target_i  in   redirect address
//   pc_o             out  current fetch PC
//   ifid_pc4_o       out  IF/ID latched PC+4
//   ifid_instr_o     out  IF/ID latched instruction
//   ifid_valid_o     out  IF/ID holds a real instruction
//   misalign_o       out  sticky: a misaligned branch target was seen
//   fetch_cnt_o      out  number of valid instructions latched into IF/ID
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal fetch; stall_i holds the stage
// FLUSH | post-branch bubbles; PC held, stall_i ignored
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FLUSH_BUBBLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] instr_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] pc_o,
   output logic [31:0] ifid_pc4_o,
   output logic [31:0] ifid_instr_o,
   output logic        ifid_valid_o,
   output logic        misalign_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   localparam logic [1:0] BUB_RELOAD = 2'(FLUSH_BUBBLES - 1);
   // With a single bubble the redirect cycle itself is the whole flush.
   localparam state_t     BR_STATE   = (FLUSH_BUBBLES > 1) ? ST_FLUSH : ST_RUN;

   state_t      r_state, w_state;
   logic [1:0]  r_bub_cnt, w_bub_cnt;
   logic [31:0] r_pc, w_pc;
   logic [31:0] r_pc4, w_pc4;
   logic [31:0] r_instr, w_instr;
   logic        r_valid, w_valid;
   logic        r_misalign, w_misalign;
   logic [31:0] r_fetch_cnt, w_fetch_cnt;

   always_comb begin
      w_state     = r_state;
      w_bub_cnt   = r_bub_cnt;
      w_pc        = r_pc;
      w_pc4       = r_pc4;
      w_instr     = r_instr;
      w_valid     = r_valid;
      w_misalign  = r_misalign;
      w_fetch_cnt = r_fetch_cnt;

      if (branch_taken_i) begin
         w_pc       = {branch_target_i[31:2], 2'b00};
         w_instr    = 32'h0;
         w_valid    = 1'b0;
         w_bub_cnt  = BUB_RELOAD;
         w_state    = BR_STATE;
         w_misalign = r_misalign | (|branch_target_i[1:0]);
      end else begin
         case (r_state)
            ST_RUN: begin
               if (!stall_i) begin
                  w_pc        = pc_plus4_i;
                  w_pc4       = pc_plus4_i;
                  w_instr     = instr_i;
                  w_valid     = 1'b1;
                  w_fetch_cnt = r_fetch_cnt + 32'd1;
               end
            end
            ST_FLUSH: begin
               w_instr   = 32'h0;
               w_valid   = 1'b0;
               w_bub_cnt = (r_bub_cnt == 2'd0) ? 2'd0 : r_bub_cnt - 2'd1;
               // Leave on the edge where the counter lands on zero.
               w_state   = (r_bub_cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
            end
            default: w_state = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state     <= ST_RUN;
         r_bub_cnt   <= 2'd0;
         r_pc        <= RESET_PC;
         r_pc4       <= 32'h0;
         r_instr     <= 32'h0;
         r_valid     <= 1'b0;
         r_misalign  <= 1'b0;
         r_fetch_cnt <= 32'h0;
      end else begin
         r_state     <= w_state;
         r_bub_cnt   <= w_bub_cnt;
         r_pc        <= w_pc;
         r_pc4       <= w_pc4;
         r_instr     <= w_instr;
         r_valid     <= w_valid;
         r_misalign  <= w_misalign;
         r_fetch_cnt <= w_fetch_cnt;
      end
   end

   assign pc_o         = r_pc;
   assign ifid_pc4_o   = r_pc4;
   assign ifid_instr_o = r_instr;
   assign ifid_valid_o = r_valid;
   assign misalign_o   = r_misalign;
   assign fetch_cnt_o  = r_fetch_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage with FLUSH_BUBBLES = 3. A reference model
// tracks the expected stage contents every cycle; literal checks pin the
// model at the interesting points.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

   localparam int          FB      = 3;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] I_XOR   = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic [31:0] pc_plus4, instr;
   logic [31:0] pc, ifid_pc4, ifid_instr, fetch_cnt;
   logic        ifid_valid, misalign;

   assign pc_plus4 = pc + 32'd4;
   assign instr    = pc ^ I_XOR;

   if_fetch_stage #(.RESET_PC(RST_PC), .FLUSH_BUBBLES(FB)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .pc_plus4_i      (pc_plus4),
      .instr_i         (instr),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (tgt),
      .pc_o            (pc),
      .ifid_pc4_o      (ifid_pc4),
      .ifid_instr_o    (ifid_instr),
      .ifid_valid_o    (ifid_valid),
      .misalign_o      (misalign),
      .fetch_cnt_o     (fetch_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the IF/ID register and PC must hold.
   logic        m_known = 1'b0;
   logic [31:0] m_pc, m_pc4, m_instr, m_cnt;
   logic        m_valid, m_mis;
   int          m_left;   // bubble cycles still owed after a redirect

   always @(posedge clk) begin
      logic [31:0] old_pc;
      if (!rst) begin
         m_known = 1'b1;
         m_pc = RST_PC; m_pc4 = 0; m_instr = 0; m_valid = 0;
         m_mis = 0; m_cnt = 0; m_left = 0;
      end else if (m_known) begin
         if (br) begin
            m_mis   = m_mis | (tgt[1:0] != 2'b00);
            m_pc    = {tgt[31:2], 2'b00};
            m_instr = 0;
            m_valid = 0;
            m_left  = FB - 1;
         end else if (m_left > 0) begin
            m_instr = 0;
            m_valid = 0;
            m_left  = m_left - 1;
         end else if (!stall) begin
            old_pc  = m_pc;
            m_pc    = old_pc + 32'd4;
            m_pc4   = old_pc + 32'd4;
            m_instr = old_pc ^ I_XOR;
            m_valid = 1;
            m_cnt   = m_cnt + 32'd1;
         end
      end
      #1;
      if (m_known) begin
         chk("model_pc",    pc,                 m_pc);
         chk("model_pc4",   ifid_pc4,           m_pc4);
         chk("model_instr", ifid_instr,         m_instr);
         chk("model_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
         chk("model_mis",   {31'b0, misalign},   {31'b0, m_mis});
         chk("model_cnt",   fetch_cnt,          m_cnt);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Reset, then free run three edges.
      rst = 1'b0;
      tick(2);
      chk("rst_pc",    pc,         RST_PC);
      chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
      chk("rst_cnt",   fetch_cnt,  32'd0);
      rst = 1'b1;
      tick(3);
      chk("run3_pc",    pc,         32'h0000_000C);
      chk("run3_pc4",   ifid_pc4,   32'h0000_000C);
      chk("run3_instr", ifid_instr, 32'hA5A5_0008);
      chk("run3_cnt",   fetch_cnt,  32'd3);

      // Stall at pc 0x8 for two cycles.
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(2);
      stall = 1'b1;
      tick(2);
      chk("stall_pc",    pc,         32'h0000_0008);
      chk("stall_pc4",   ifid_pc4,   32'h0000_0008);
      chk("stall_instr", ifid_instr, 32'hA5A5_0004);
      chk("stall_cnt",   fetch_cnt,  32'd2);
      stall = 1'b0;
      tick(1);
      chk("resume_pc",  pc,        32'h0000_000C);
      chk("resume_cnt", fetch_cnt, 32'd3);

      // Branch with simultaneous stall; stall kept high through the flush.
      br = 1'b1; tgt = 32'h0000_0100; stall = 1'b1;
      tick(1);
      br = 1'b0;
      chk("br_pc",    pc, 32'h0000_0100);
      chk("br_valid", {31'b0, ifid_valid}, 32'd0);
      tick(2);
      chk("flush_pc",    pc, 32'h0000_0100);
      chk("flush_valid", {31'b0, ifid_valid}, 32'd0);
      stall = 1'b0;
      tick(1);
      chk("post_pc4",   ifid_pc4,   32'h0000_0104);
      chk("post_valid", {31'b0, ifid_valid}, 32'd1);
      chk("post_instr", ifid_instr, 32'hA5A5_0100);
      chk("post_cnt",   fetch_cnt,  32'd4);

      // Misaligned target, then an aligned branch taken mid-flush.
      br = 1'b1; tgt = 32'h0000_0203;
      tick(1);
      br = 1'b0;
      chk("mis_pc",  pc, 32'h0000_0200);
      chk("mis_set", {31'b0, misalign}, 32'd1);
      tick(1);
      br = 1'b1; tgt = 32'h0000_0040;
      tick(1);
      br = 1'b0;
      chk("mis_sticky", {31'b0, misalign}, 32'd1);
      chk("rebr_pc",    pc, 32'h0000_0040);
      tick(3);
      chk("rebr_run_pc", pc, 32'h0000_0044);

      // Reset mid-flush, with a branch request also present.
      br = 1'b1; tgt = 32'h0000_0080;
      tick(1);
      br = 1'b0;
      tick(1);
      rst = 1'b0; br = 1'b1; tgt = 32'h0000_0300; stall = 1'b1;
      tick(1);
      br = 1'b0; stall = 1'b0;
      chk("midrst_pc",    pc,         RST_PC);
      chk("midrst_pc4",   ifid_pc4,   32'd0);
      chk("midrst_instr", ifid_instr, 32'd0);
      chk("midrst_mis",   {31'b0, misalign}, 32'd0);
      chk("midrst_cnt",   fetch_cnt,  32'd0);
      rst = 1'b1;
      tick(1);
      chk("rst_run_pc",    pc, 32'h0000_0004);
      chk("rst_run_valid", {31'b0, ifid_valid}, 32'd1);

      // PC wrap through the external adder.
      br = 1'b1; tgt = 32'hFFFF_FFFC;
      tick(1);
      br = 1'b0;
      tick(2);
      chk("wrap_hold_pc", pc, 32'hFFFF_FFFC);
      tick(1);
      chk("wrap_pc",    pc,         32'h0000_0000);
      chk("wrap_pc4",   ifid_pc4,   32'h0000_0000);
      chk("wrap_instr", ifid_instr, 32'h5A5A_FFFC);

      // Fetch counter wrap.
      force dut.r_fetch_cnt = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_fetch_cnt;
      chk("cnt_preload", fetch_cnt, 32'hFFFF_FFFF);
      tick(1);
      chk("cnt_wrap", fetch_cnt, 32'd0);
      tick(2);
      chk("cnt_after", fetch_cnt, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
